// File: rtl/ctrl_link_pkg.sv
// Shared constants, state encoding and helpers for the 2-bit control link.
// The initiator side uses the same frame constants.
package ctrl_link_pkg;

    localparam int FRAME_BITS   = 144;
    localparam int PAYLOAD_BITS = 128;
    localparam int FRAME_DIBITS = 72;

    localparam logic [15:0] TRAILER = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RECV = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_SYNC = 3'd4
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ctrl_dibit_serializer.sv
// Shifts a loaded 144-bit frame onto the link, MSB dibit first, one dibit per cycle.
// The shift register drains to zero, so the data output is idle-low without gating.
module ctrl_dibit_serializer
    import ctrl_link_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] frame,
    output logic [1:0]            ctrl_tx_data,
    output logic                  ctrl_tx_en,
    output logic                  done
);

    localparam logic [6:0] LAST_DIBIT = 7'(FRAME_DIBITS - 1);

    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [6:0]            cnt_q, cnt_d;
    logic                  en_q, en_d;

    assign done         = en_q && (cnt_q == LAST_DIBIT);
    assign ctrl_tx_data = sh_q[FRAME_BITS-1 -: 2];
    assign ctrl_tx_en   = en_q;

    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        en_d  = en_q;
        if (load) begin
            sh_d  = frame;
            cnt_d = 7'd0;
            en_d  = 1'b1;
        end else if (en_q) begin
            sh_d  = {sh_q[FRAME_BITS-3:0], 2'b00};
            cnt_d = cnt_q + 7'd1;
            if (done) en_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/ctrl_package_responder.sv
// Far-end responder: deserializes and validates a control frame, then answers
// good frames with a latched response payload after a fixed turnaround.
module ctrl_package_responder
    import ctrl_link_pkg::*;
#(
    parameter int TURNAROUND = 4
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic [1:0]              ctrl_rx_data,
    input  logic                    ctrl_rx_dv,
    output logic [1:0]              ctrl_tx_data,
    output logic                    ctrl_tx_en,
    input  logic                    rsp_en,
    input  logic [PAYLOAD_BITS-1:0] rsp_package_i,
    output logic [PAYLOAD_BITS-1:0] rx_package_o,
    output logic                    rx_valid,
    output logic                    rx_err,
    output logic                    busy,
    output logic [15:0]             frame_cnt,
    output logic [15:0]             err_cnt
);

    localparam logic [6:0] CNT_FULL  = 7'(FRAME_DIBITS);
    localparam logic [6:0] CNT_SAT   = 7'(FRAME_DIBITS + 1);
    localparam logic [7:0] WAIT_INIT = 8'(TURNAROUND - 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [6:0]              dibit_cnt_q, dibit_cnt_d;
    logic [7:0]              wait_cnt_q, wait_cnt_d;
    logic [PAYLOAD_BITS-1:0] rsp_q, rsp_d;
    logic [PAYLOAD_BITS-1:0] rx_pkg_q, rx_pkg_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_err_q, rx_err_d;
    logic                    busy_q, busy_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [15:0]             err_cnt_q, err_cnt_d;
    logic                    dv_q;
    logic                    load;
    logic                    done;
    logic                    dv_rise;

    assign dv_rise = ctrl_rx_dv && !dv_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        dibit_cnt_d = dibit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_d       = rsp_q;
        rx_pkg_d    = rx_pkg_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_rx_dv) begin
                    shift_d     = {shift_q[FRAME_BITS-3:0], ctrl_rx_data};
                    dibit_cnt_d = 7'd1;
                    state_d     = ST_RECV;
                end
            end
            ST_RECV: begin
                if (ctrl_rx_dv) begin
                    shift_d = {shift_q[FRAME_BITS-3:0], ctrl_rx_data};
                    if (dibit_cnt_q < CNT_SAT) dibit_cnt_d = dibit_cnt_q + 7'd1;
                end else if (dibit_cnt_q == CNT_FULL && shift_q[15:0] == TRAILER) begin
                    rx_valid_d  = 1'b1;
                    rx_pkg_d    = shift_q[FRAME_BITS-1:16];
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    rsp_d       = rsp_package_i;
                    wait_cnt_d  = WAIT_INIT;
                    state_d     = rsp_en ? ST_WAIT : ST_IDLE;
                end else begin
                    rx_err_d  = 1'b1;
                    err_cnt_d = sat_inc16(err_cnt_q);
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Link is ours while answering; an incoming frame is lost.
                if (dv_rise) err_cnt_d = sat_inc16(err_cnt_q);
                if (wait_cnt_q == 8'd0) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            ST_SEND: begin
                if (dv_rise) err_cnt_d = sat_inc16(err_cnt_q);
                if (done) state_d = ctrl_rx_dv ? ST_SYNC : ST_IDLE;
            end
            ST_SYNC: begin
                if (!ctrl_rx_dv) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RECV) || (state_d == ST_WAIT) || (state_d == ST_SEND);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            dibit_cnt_q <= '0;
            wait_cnt_q  <= '0;
            rsp_q       <= '0;
            rx_pkg_q    <= '0;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
            dv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            dibit_cnt_q <= dibit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_q       <= rsp_d;
            rx_pkg_q    <= rx_pkg_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
            dv_q        <= ctrl_rx_dv;
        end
    end

    ctrl_dibit_serializer u_ser (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .load         (load),
        .frame        ({rsp_q, TRAILER}),
        .ctrl_tx_data (ctrl_tx_data),
        .ctrl_tx_en   (ctrl_tx_en),
        .done         (done)
    );

    assign rx_package_o = rx_pkg_q;
    assign rx_valid     = rx_valid_q;
    assign rx_err       = rx_err_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: doc/ctrl_package_responder.md
# ctrl_package_responder

Far-end responder for the 2-bit control link driven by the control package transceiver. Deserializes one 144-bit frame (128-bit payload plus 16'hFFFF trailer, MSB dibit first) on `ctrl_rx_data`/`ctrl_rx_dv`, validates length and trailer, and presents the payload. On a good frame with `rsp_en` high, it returns a 144-bit response frame on `ctrl_tx_data`/`ctrl_tx_en` after a fixed turnaround. Sits on the remote board or in loopback test fixtures, opposite the initiator.

## Interface
- `TURNAROUND`, default 4: cycles from the `rx_valid` rising edge to the first `ctrl_tx_en` high. Legal range 1..255.

Ports:
- `sys_clk` in 1: single clock; both rx sampling and tx launch use it.
- `rst_n` in 1: asynchronous, active-low reset.
- `ctrl_rx_data` in 2: received dibit, sampled on `sys_clk` rising edge.
- `ctrl_rx_dv` in 1: high for every valid dibit of a frame.
- `ctrl_tx_data` out 2: response dibit; 2'b00 whenever `ctrl_tx_en` is low.
- `ctrl_tx_en` out 1: high for exactly 72 cycles per response.
- `rsp_en` in 1: enables automatic response to good frames.
- `rsp_package_i` in 128: response payload, latched when `rx_valid` is set.
- `rx_package_o` out 128: payload of the last good frame; holds until the next good frame.
- `rx_valid` out 1: one-cycle pulse per good frame.
- `rx_err` out 1: one-cycle pulse per bad frame.
- `busy` out 1: high in RECV, WAIT, and SEND.
- `frame_cnt` out 16: good-frame count; wraps.
- `err_cnt` out 16: bad plus dropped frame count; saturates at 16'hFFFF.

## Operation
- FSM states: IDLE, RECV, WAIT, SEND, SYNC.
- **IDLE:** when `ctrl_rx_dv`=1, shift in the dibit, set `dibit_cnt`=1, and go to RECV.
- **RECV:** while `dv`=1, shift left by 2 (new dibit into LSBs). `dibit_cnt` increments and saturates at 73.
- **RECV, `dv`=0 (edge E0):** the frame is good iff `dibit_cnt`==72 and `shift[15:0]`==16'hFFFF.
  - Good: at E0 set `rx_valid`=1, `rx_package_o`=`shift[143:16]`, `frame_cnt`+1, and latch `rsp_package_i`. Go to WAIT if `rsp_en`, else IDLE.
  - Bad: at E0 set `rx_err`=1 and `err_cnt`+1, then go to IDLE.
- **WAIT:** count down `TURNAROUND`-1 further cycles, then go to SEND.
- **SEND:** 72 cycles with `ctrl_tx_en`=1, sending `{latched_rsp, 16'hFFFF}` MSB dibit first (bits [143:142] first, [1:0] last). Then go to IDLE, or to SYNC if `dv`=1.
- **Half-duplex rules:**
  - `dv` rising during WAIT or SEND: the frame is dropped, not shifted, and counted once in `err_cnt`. `rx_err` does not pulse.
  - **SYNC:** waits for `dv`=0 before returning to IDLE, so a partial frame is never accepted.
- **Reset:** any time `rst_n`=0, all outputs go to 0, counters clear, and the FSM returns to IDLE. An in-flight tx or rx is abandoned with no further pulses.

## Timing
- Registered outputs only; no combinational path from input to output.
- `rx_valid`/`rx_err` are high in the cycle following E0. E0 is the first edge that samples `dv`=0 after the last dibit.
- First response dibit is on the wire `TURNAROUND` cycles after `rx_valid` rises. The last dibit is at +71 from that point. `ctrl_tx_en` falls on the next edge.
- The minimum gap before a new frame is accepted is the end of SEND. With `rsp_en`=0, IDLE is reached at E0, so back-to-back frames separated by one idle `dv` cycle are accepted.
- `dv` high during the E0 edge cannot occur in RECV, because E0 is defined by `dv`=0. A frame longer than 72 dibits is flagged bad when `dv` finally drops.

## Structure
- Package `ctrl_link_pkg` holds:
  - `FRAME_BITS`=144, `PAYLOAD_BITS`=128, `FRAME_DIBITS`=72.
  - `TRAILER`=16'hFFFF.
  - The FSM state enum.
- The initiator uses the same constants.
- One sub-module, `ctrl_dibit_serializer`:
  - Inputs: `load` (1-cycle), 144-bit frame.
  - Outputs: `ctrl_tx_data`, `ctrl_tx_en`, `done`.
  - Owns the SEND counter.

## Test plan
- **Good frame, `rsp_en`=1, `TURNAROUND`=4:** send payload 128'hA5B6C7D8_E9FA0B1C_2D3E4F50_61728394 plus FFFF. Required:
  - `rx_package_o` equals the payload; one `rx_valid` pulse; `frame_cnt`=1.
  - `ctrl_tx_en` rises 4 cycles after `rx_valid` and stays high 72 cycles.
  - Wire carries `{rsp_package_i, FFFF}` MSB first.
- **Short frame (71 dibits) and long frame (73 dibits):** each gives one `rx_err` pulse, no `rx_valid`, `err_cnt`=2, no tx activity.
- **Bad trailer** (`shift[15:0]`=16'hFFFE): one `rx_err` pulse; `rx_package_o` keeps its previous value.
- **Frame arriving during SEND:** dropped; `err_cnt`+1; no `rx_valid`/`rx_err`. The next clean frame after `dv` goes low is accepted normally.
- **`rst_n` pulsed low at dibit 36 of SEND:** `ctrl_tx_en`=0 immediately, `ctrl_tx_data`=0, counters=0. A subsequent good frame is received and answered normally.
- **Back-to-back good frames, `rsp_en`=0, one idle cycle between:** two `rx_valid` pulses; `frame_cnt`=2; the second payload is on `rx_package_o`.
